// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// -------------
// Transmit serializer for the UART link. Runs at one bit per clock (the clock
// is already the baud rate). A byte offered with Data_Valid while idle is sent
// as: start bit (0), data LSB first, optional parity bit, one stop bit (1).
//
// Ports
//   CLK         transmit clock, one bit period per cycle, rising edge
//   RST         synchronous, active-high reset (aborts any frame in flight)
//   P_DATA      parallel payload, sampled only on the accept edge
//   Data_Valid  payload request, honoured only while IDLE
//   PAR_EN      1 = insert parity bit, sampled on the accept edge
//   PAR_TYP     0 = even, 1 = odd, sampled on the accept edge
//   TX_OUT      registered serial line, idles high
//   busy        registered, high for every cycle of a frame
//
// TX_OUT and busy are computed from the next state and registered on the same
// edge as the state, so the start bit appears in the cycle right after the
// accept edge with zero extra latency.

module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg,   state_next;
    logic [CNT_W-1:0]      cnt_reg,     cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg,   shift_next;
    logic                  par_en_reg,  par_en_next;
    logic                  par_bit_reg, par_bit_next;
    logic                  tx_reg,      tx_next;
    logic                  busy_reg,    busy_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        tx_next      = 1'b1;
        busy_next    = 1'b1;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (Data_Valid) begin
                    // Snapshot everything the frame needs; later input
                    // changes cannot reach this frame.
                    shift_next   = P_DATA;
                    par_en_next  = PAR_EN;
                    par_bit_next = (^P_DATA) ^ PAR_TYP;
                    state_next   = START;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end

            START: begin
                // The register drives TX_OUT one cycle after it is loaded,
                // so the bit leaving the shifter now is the next cycle's bit.
                state_next = DATA;
                cnt_next   = '0;
                tx_next    = shift_reg[0];
                shift_next = shift_reg >> 1;
            end

            DATA: begin
                if (cnt_reg == LAST_BIT) begin
                    if (par_en_reg) begin
                        state_next = PARITY;
                        tx_next    = par_bit_reg;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                end
            end

            PARITY: begin
                state_next = STOP;
                tx_next    = 1'b1;
            end

            STOP: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule
